conv2d_mc: RTL and testbench
============================

Name: conv2d_mc

Overview:
- Streaming multi-channel 2D convolution engine, the next generation of the single-channel line-buffered convolver in the vision pipeline.
- Accepts one raster-order pixel per handshake. Applies OutChannels independent KxK kernels in parallel to the same window.
- Adds per-channel bias, configurable stride, arithmetic post-shift, optional ReLU and signed saturation.
- Emits one registered output vector per valid window position, plus an end-of-frame marker.
- Sits between the pixel front-end (camera/threshold) and downstream feature/pooling stages.

Parameters:
- LineWidthPx, 160: pixels per line; must be >= KernelWidth.
- LineCountPx, 120: lines per frame; must be >= KernelWidth.
- WidthIn, 2: pixel width. Pixels are unsigned. WidthIn==1 is binary mask mode.
- WidthOut, 16: signed output width per channel.
- KernelWidth, 3: kernel side K (window is KxK).
- WeightWidth, 2: signed weight width.
- OutChannels, 4: number of parallel kernels/output channels.
- Stride, 1: horizontal and vertical stride S, >= 1.
- BiasWidth, 8: signed bias width.
- ShiftWidth, 4: width of the post-shift amount.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  input pixel valid.
- ready_o  out  1  block can accept a pixel.
- data_i  in  WidthIn  pixel, raster order.
- valid_o  out  1  output vector valid.
- ready_i  in  1  downstream accepts output.
- data_o  out  OutChannels x WidthOut (signed)  per-channel result; channel c at bits [c*WidthOut +: WidthOut].
- last_o  out  1  high with the final output of a frame.
- weights_i  in  OutChannels x K*K x WeightWidth (signed)  row-major, index r*K+c; row 0 is the oldest line.
- bias_i  in  OutChannels x BiasWidth (signed)  per-channel bias.
- shift_i  in  ShiftWidth  arithmetic right-shift amount.
- relu_i  in  1  clamp negative results to 0.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high.
- Reset values: valid_o=0, last_o=0, data_o=0. x/y position counters and stride phase counters = 0. Window registers = 0. Line-buffer contents need not be cleared.
- Handshake:
  - in_fire = valid_i & ready_o.
  - ready_o = ~valid_o | ready_i.
  - While valid_o & ~ready_i: data_o and last_o hold stable and no pixel is accepted.
- Position tracking:
  - x advances on each in_fire and wraps at LineWidthPx-1.
  - y advances on x wrap and wraps at LineCountPx-1 to begin the next frame with no gap.
- Produce condition, evaluated on in_fire for the accepted pixel position (x,y). All must hold:
  - x >= K-1 and y >= K-1;
  - (x-(K-1)) mod S == 0 and (y-(K-1)) mod S == 0.
  - Implement the mod S tests with phase counters, not dividers.
- Window: K-1 line delay buffers, each delaying exactly one line and stepping only on in_fire. The window shifts left on in_fire; the new right column is {line-2 delay, line-1 delay, data_i}, top to bottom.
- Output register:
  - When ready_o is high, valid_o loads the produce flag.
  - When ready_o is high and produce is set, data_o loads the result for the window that includes the just-accepted pixel.
  - Latency: pixel accepted in cycle N gives valid_o in cycle N+1.
- Arithmetic per channel:
  - Products: for WidthIn>1, signed weight x zero-extended pixel. For WidthIn==1, add the weight when the pixel is 1.
  - Sum all K*K terms at full precision; no intermediate overflow is permitted.
  - Add the sign-extended bias.
  - Arithmetic right shift by shift_i (floor toward negative infinity).
  - If relu_i, negative values become 0.
  - Saturate to [-2^(WidthOut-1), 2^(WidthOut-1)-1].
- Config inputs: weights_i, bias_i, shift_i and relu_i are sampled on the producing in_fire. Changes affect only later outputs.
- last_o: loaded together with valid_o. It is high exactly when the output corresponds to x = K-1+S*floor((W-K)/S) and y = K-1+S*floor((H-K)/S).
- Outputs per frame: (floor((W-K)/S)+1) x (floor((H-K)/S)+1).
- Reset mid-frame: the output in flight is dropped. The next accepted pixel is frame position (0,0). No output uses pre-reset pixels, because produce is suppressed until K-1 fresh lines have been buffered.
- Simultaneous accept and drain: if the output register holds data and ready_i=1, a new in_fire may load the register in the same cycle. If that pixel does not produce, valid_o goes to 0.

Test Plan:
- Constant image: W=6, H=5, K=3, S=1, WidthIn=2, all pixels 3, weights all +1, bias 0, shift 0 -> 12 outputs, each channel = 27; last_o only on the 12th; first valid_o one cycle after pixel (2,2) is accepted.
- Bias, ReLU, saturation: weights all -2, pixels 3, WidthOut=8.
  - bias 0 -> -54.
  - shift 1 -> -27.
  - relu_i=1 -> 0.
  - WidthOut=4 with weights +1 -> 7; with weights -2 -> -8.
- Channel independence: OutChannels=4, channel c weights = one-hot at tap c, ramp image pixel=(x+y)&3 -> each channel matches the reference model per window.
- Stride: W=6, H=5, K=3, S=2 -> exactly 4 outputs at (2,2),(4,2),(2,4),(4,4); last_o on (4,4).
- Backpressure: drop ready_i for 5 cycles mid-line with valid_i held high -> ready_o=0 while full, data_o stable, output sequence identical to the no-stall run.
- Reset mid-frame: assert rst_i after 17 pixels, then stream a full frame -> valid_o=0 the cycle after reset, exactly 12 outputs (S=1), values correct for the new frame only.

Source files
------------

// File: rtl/conv2d_mc.sv
// conv2d_mc: streaming multi-channel KxK convolution engine.
// Raster pixels feed K-1 line delays and a KxK window; OutChannels kernels are
// applied in parallel, followed by bias, arithmetic shift, optional ReLU and
// signed saturation into a single registered output stage with handshake.
module conv2d_mc #(
    parameter int LineWidthPx = 160,
    parameter int LineCountPx = 120,
    parameter int WidthIn     = 2,
    parameter int WidthOut    = 16,
    parameter int KernelWidth = 3,
    parameter int WeightWidth = 2,
    parameter int OutChannels = 4,
    parameter int Stride      = 1,
    parameter int BiasWidth   = 8,
    parameter int ShiftWidth  = 4
) (
    input  logic                                                      clk_i,
    input  logic                                                      rst_i,
    input  logic                                                      valid_i,
    output logic                                                      ready_o,
    input  logic [WidthIn-1:0]                                        data_i,
    output logic                                                      valid_o,
    input  logic                                                      ready_i,
    output logic [OutChannels*WidthOut-1:0]                           data_o,
    output logic                                                      last_o,
    input  logic [OutChannels*KernelWidth*KernelWidth*WeightWidth-1:0] weights_i,
    input  logic [OutChannels*BiasWidth-1:0]                          bias_i,
    input  logic [ShiftWidth-1:0]                                     shift_i,
    input  logic                                                      relu_i
);
    localparam int K     = KernelWidth;
    localparam int Taps  = K * K;
    localparam int XW    = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
    localparam int YW    = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
    localparam int SW    = (Stride > 1) ? $clog2(Stride) : 1;
    localparam int LastX = K - 1 + Stride * ((LineWidthPx - K) / Stride);
    localparam int LastY = K - 1 + Stride * ((LineCountPx - K) / Stride);
    // Accumulator is wide enough that neither the K*K sum nor the bias add can overflow.
    localparam int ProdW = WeightWidth + WidthIn + 1;
    localparam int SumW  = ProdW + $clog2(Taps + 1);
    localparam int AccW0 = (SumW > BiasWidth) ? SumW : BiasWidth;
    localparam int AccW  = ((AccW0 > WidthOut) ? AccW0 : WidthOut) + 1;
    localparam logic signed [AccW-1:0] SatMax = AccW'((2 ** (WidthOut - 1)) - 1);
    localparam logic signed [AccW-1:0] SatMin = ~SatMax;

    logic                            valid_q;
    logic                            last_q;
    logic [OutChannels*WidthOut-1:0] data_q;
    logic                            in_fire;
    logic                            x_wrap;
    logic                            produce;
    logic                            is_last;
    logic [XW-1:0]                   x_q, x_d;
    logic [YW-1:0]                   y_q, y_d;
    logic [SW-1:0]                   px_q, px_d;
    logic [SW-1:0]                   py_q, py_d;
    logic [XW-1:0]                   rd_addr;
    logic [WidthIn-1:0]              dly_col [K];
    logic [WidthIn-1:0]              win_q [K][K];
    logic [WidthIn-1:0]              win_d [K][K];
    logic [OutChannels*WidthOut-1:0] result_d;

    assign ready_o = ~valid_q | ready_i;
    assign in_fire = valid_i & ready_o;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q;

    assign x_wrap  = (x_q == XW'(LineWidthPx - 1));
    // Phase counters are zero exactly on positions aligned to the stride grid.
    assign produce = (x_q >= XW'(K - 1)) && (y_q >= YW'(K - 1)) &&
                     (px_q == '0) && (py_q == '0);
    assign is_last = (x_q == XW'(LastX)) && (y_q == YW'(LastY));

    // Next raster position and stride phases for the pixel after the accepted one
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        px_d = px_q;
        py_d = py_q;
        if (in_fire) begin
            if (x_wrap) begin
                x_d  = '0;
                px_d = '0;
                if (y_q == YW'(LineCountPx - 1)) begin
                    y_d  = '0;
                    py_d = '0;
                end else begin
                    y_d = y_q + 1'b1;
                    if (y_q >= YW'(K - 1)) begin
                        py_d = (py_q == SW'(Stride - 1)) ? '0 : py_q + 1'b1;
                    end
                end
            end else begin
                x_d = x_q + 1'b1;
                if (x_q >= XW'(K - 1)) begin
                    px_d = (px_q == SW'(Stride - 1)) ? '0 : px_q + 1'b1;
                end
            end
        end
    end

    // Position and phase registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q  <= '0;
            y_q  <= '0;
            px_q <= '0;
            py_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            px_q <= px_d;
            py_q <= py_d;
        end
    end

    // The line RAMs are read one cycle ahead at the address of the next pixel,
    // so the registered read data is ready when that pixel is accepted.
    assign rd_addr    = rst_i ? '0 : x_d;
    assign dly_col[0] = data_i;

    genvar gi;
    generate
        for (gi = 1; gi < K; gi++) begin : g_line
            logic [WidthIn-1:0] line_mem [LineWidthPx];
            logic [WidthIn-1:0] line_rd_q;

            // One-line delay: write the incoming column value, prefetch the next slot
            always_ff @(posedge clk_i) begin
                if (in_fire) begin
                    line_mem[x_q] <= dly_col[gi-1];
                end
                line_rd_q <= line_mem[rd_addr];
            end

            assign dly_col[gi] = line_rd_q;
        end
    endgenerate

    // Window after the current pixel: shift left, new right column oldest line on top
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][K-1] = dly_col[K-1-r];
        end
    end

    // Window registers advance only on accepted pixels
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (in_fire) begin
            win_q <= win_d;
        end
    end

    generate
        for (gi = 0; gi < OutChannels; gi++) begin : g_chan
            logic signed [AccW-1:0] acc_d;
            logic signed [AccW-1:0] shifted_d;
            logic [WidthOut-1:0]    res_d;

            // Full-precision dot product of the window with this channel's kernel, plus bias
            always_comb begin
                logic [WeightWidth-1:0] w;
                logic [BiasWidth-1:0]   b;
                logic [WidthIn-1:0]     pix;
                b     = bias_i[gi*BiasWidth +: BiasWidth];
                w     = '0;
                pix   = '0;
                acc_d = {{(AccW-BiasWidth){b[BiasWidth-1]}}, b};
                for (int t = 0; t < Taps; t++) begin
                    w   = weights_i[(gi*Taps + t)*WeightWidth +: WeightWidth];
                    pix = win_d[t / K][t % K];
                    if (WidthIn == 1) begin
                        if (pix[0]) begin
                            acc_d = acc_d + {{(AccW-WeightWidth){w[WeightWidth-1]}}, w};
                        end
                    end else begin
                        acc_d = acc_d + {{(AccW-WeightWidth){w[WeightWidth-1]}}, w} *
                                        {{(AccW-WidthIn){1'b0}}, pix};
                    end
                end
            end

            // Floor shift, optional ReLU, then clamp into the signed output range
            always_comb begin
                shifted_d = acc_d >>> shift_i;
                if (relu_i && shifted_d[AccW-1]) begin
                    shifted_d = '0;
                end
                if (shifted_d > SatMax) begin
                    res_d = SatMax[WidthOut-1:0];
                end else if (shifted_d < SatMin) begin
                    res_d = SatMin[WidthOut-1:0];
                end else begin
                    res_d = shifted_d[WidthOut-1:0];
                end
            end

            assign result_d[gi*WidthOut +: WidthOut] = res_d;
        end
    endgenerate

    // Output stage: reloads whenever it is empty or being drained, holds on stall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (ready_o) begin
            valid_q <= in_fire & produce;
            last_q  <= in_fire & produce & is_last;
            if (in_fire & produce) begin
                data_q <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_mc.sv
// Bench for conv2d_mc: two instances (stride 1 / 8-bit out, stride 2 / 4-bit out)
// checked against a window-sum reference model computed from stored frames.
`timescale 1ns/1ps
module tb_conv2d_mc;
    localparam int W = 6, H = 5, K = 3, WI = 2, WW = 2, OC = 4, BW = 8, SHW = 4;
    localparam int WO0 = 8, WO1 = 4, S1 = 2;
    localparam int TAPS = K * K;

    logic clk = 1'b0;
    logic rst;
    logic vld0, vld1, rdy_i0, rdy_i1, rdy_o0, rdy_o1, vo0, vo1, last0, last1;
    logic [WI-1:0] din;
    logic [OC*WO0-1:0] dout0;
    logic [OC*WO1-1:0] dout1;
    logic [OC*TAPS*WW-1:0] wts;
    logic [OC*BW-1:0] bias;
    logic [SHW-1:0] shamt;
    logic relu;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit b2b_done;

    int img [2][H][W];
    int wt [OC][TAPS];
    int bs [OC];
    int sh;
    bit rl;

    int exp_q[$];
    bit expl_q[$];
    int got0_q[$], got1_q[$];
    bit gotl0_q[$], gotl1_q[$];
    int gotc0_q[$];
    int fire_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d_mc #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(WI), .WidthOut(WO0),
                .KernelWidth(K), .WeightWidth(WW), .OutChannels(OC), .Stride(1),
                .BiasWidth(BW), .ShiftWidth(SHW)) dut0 (
        .clk_i(clk), .rst_i(rst), .valid_i(vld0), .ready_o(rdy_o0), .data_i(din),
        .valid_o(vo0), .ready_i(rdy_i0), .data_o(dout0), .last_o(last0),
        .weights_i(wts), .bias_i(bias), .shift_i(shamt), .relu_i(relu));

    conv2d_mc #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(WI), .WidthOut(WO1),
                .KernelWidth(K), .WeightWidth(WW), .OutChannels(OC), .Stride(S1),
                .BiasWidth(BW), .ShiftWidth(SHW)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(vld1), .ready_o(rdy_o1), .data_i(din),
        .valid_o(vo1), .ready_i(rdy_i1), .data_o(dout1), .last_o(last1),
        .weights_i(wts), .bias_i(bias), .shift_i(shamt), .relu_i(relu));

    // Output collectors: record every transfer seen away from the clock edge.
    always @(negedge clk) begin
        if (!rst && vo0 && rdy_i0) begin
            for (int c = 0; c < OC; c++) got0_q.push_back(int'($signed(dout0[c*WO0 +: WO0])));
            gotl0_q.push_back(last0);
            gotc0_q.push_back(cyc);
        end
        if (!rst && vo1 && rdy_i1) begin
            for (int c = 0; c < OC; c++) got1_q.push_back(int'($signed(dout1[c*WO1 +: WO1])));
            gotl1_q.push_back(last1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int model(input int f, input int ch, input int x, input int y, input int wo);
        int acc;
        acc = bs[ch];
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                acc += wt[ch][r*K+c] * img[f][y-K+1+r][x-K+1+c];
        acc = acc >>> sh;
        if (rl && acc < 0) acc = 0;
        if (acc > (1 << (wo-1)) - 1) acc = (1 << (wo-1)) - 1;
        if (acc < -(1 << (wo-1))) acc = -(1 << (wo-1));
        return acc;
    endfunction

    task automatic build_exp(input int f, input int s, input int wo);
        for (int y = K-1; y < H; y += s)
            for (int x = K-1; x < W; x += s) begin
                for (int c = 0; c < OC; c++) exp_q.push_back(model(f, c, x, y, wo));
                expl_q.push_back((x + s >= W) && (y + s >= H));
            end
    endtask

    task automatic apply_cfg();
        for (int c = 0; c < OC; c++) begin
            for (int t = 0; t < TAPS; t++) wts[(c*TAPS+t)*WW +: WW] = WW'(wt[c][t]);
            bias[c*BW +: BW] = BW'(bs[c]);
        end
        shamt = SHW'(sh);
        relu  = rl;
    endtask

    task automatic set_cfg_const(input int wv, input int bv, input int shv, input bit rv);
        for (int c = 0; c < OC; c++) begin
            for (int t = 0; t < TAPS; t++) wt[c][t] = wv;
            bs[c] = bv;
        end
        sh = shv;
        rl = rv;
        apply_cfg();
    endtask

    task automatic set_cfg_rand(input int maxsh);
        for (int c = 0; c < OC; c++) begin
            for (int t = 0; t < TAPS; t++) wt[c][t] = int'($urandom_range(3)) - 2;
            bs[c] = int'($urandom_range(60)) - 30;
        end
        sh = int'($urandom_range(maxsh));
        rl = 1'($urandom_range(1));
        apply_cfg();
    endtask

    task automatic fill_img(input int f, input int mode, input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[f][y][x] = (mode == 0) ? v : (mode == 1) ? ((x + y) & 3) : int'($urandom_range(3));
    endtask

    task automatic clear_q();
        exp_q.delete(); expl_q.delete();
        got0_q.delete(); got1_q.delete(); gotl0_q.delete(); gotl1_q.delete();
        gotc0_q.delete(); fire_cyc.delete();
    endtask

    // Streams npix raster pixels of frame f into dut sel; called at posedge+1 phase.
    task automatic send_frame(input int sel, input int f, input int npix);
        bit ok;
        for (int i = 0; i < npix; i++) begin
            din = WI'(img[f][i / W][i % W]);
            if (sel == 0) vld0 = 1'b1; else vld1 = 1'b1;
            ok = 1'b0;
            for (int n = 0; n < 200 && !ok; n++) begin
                @(negedge clk);
                ok = (sel == 0) ? rdy_o0 : rdy_o1;
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL send_timeout dut=%0d pixel=%0d ready_o stayed 0", sel, i);
            end
            fire_cyc.push_back(cyc);
            @(posedge clk); #1;
        end
        vld0 = 1'b0;
        vld1 = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; vld0 = 1'b0; vld1 = 1'b0; rdy_i0 = 1'b0; rdy_i1 = 1'b0; din = '0;
        set_cfg_const(0, 0, 0, 1'b0);
        repeat (3) @(posedge clk); #1;
        @(negedge clk);
        checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", vo0); end
        checks++; if (last0 !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", last0); end
        checks++; if (dout0 !== '0) begin errors++; $display("FAIL reset_data got %h want 0", dout0); end
        checks++; if (rdy_o0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", rdy_o0); end
        checks++; if (vo1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b want 0", vo1); end
        @(posedge clk); #1;
        rst = 1'b0; rdy_i0 = 1'b1; rdy_i1 = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_constant();
        clear_q();
        fill_img(0, 0, 3);
        set_cfg_const(1, 0, 0, 1'b0);
        send_frame(0, 0, W*H);
        drain();
        checks++; if (gotl0_q.size() !== 12) begin errors++; $display("FAIL const_count got %0d want 12", gotl0_q.size()); end
        for (int i = 0; i < got0_q.size(); i++) begin
            checks++; if (got0_q[i] !== 27) begin errors++; $display("FAIL const_value idx=%0d got %0d want 27", i, got0_q[i]); end
        end
        for (int i = 0; i < gotl0_q.size(); i++) begin
            checks++; if (gotl0_q[i] !== (i == 11)) begin errors++; $display("FAIL const_last idx=%0d got %b want %b", i, gotl0_q[i], i == 11); end
        end
        checks++;
        if (gotc0_q.size() == 0 || fire_cyc.size() < 2*W+3) begin
            errors++; $display("FAIL const_latency no output or missing fires");
        end else if (gotc0_q[0] !== fire_cyc[2*W+2] + 1) begin
            errors++; $display("FAIL const_latency got cycle %0d want %0d", gotc0_q[0], fire_cyc[2*W+2] + 1);
        end
        $display("test_constant outputs=%0d", gotl0_q.size());
    endtask

    task automatic test_bias_relu_sat();
        int cw [5] = '{-2, -2, -2, 1, -2};
        int cb [5] = '{0, 0, 0, 127, -128};
        int cs [5] = '{0, 1, 0, 0, 0};
        bit cr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int ce [5] = '{-54, -27, 0, 127, -128};
        fill_img(0, 0, 3);
        for (int k = 0; k < 5; k++) begin
            clear_q();
            set_cfg_const(cw[k], cb[k], cs[k], cr[k]);
            send_frame(0, 0, W*H);
            drain();
            checks++; if (got0_q.size() !== 12*OC) begin errors++; $display("FAIL brs_count case=%0d got %0d want %0d", k, got0_q.size(), 12*OC); end
            for (int i = 0; i < got0_q.size(); i++) begin
                checks++; if (got0_q[i] !== ce[k]) begin errors++; $display("FAIL brs_value case=%0d idx=%0d got %0d want %0d", k, i, got0_q[i], ce[k]); end
            end
            $display("test_bias_relu_sat case=%0d want=%0d", k, ce[k]);
        end
    endtask

    task automatic test_channels();
        clear_q();
        fill_img(0, 1, 0);
        for (int c = 0; c < OC; c++) begin
            for (int t = 0; t < TAPS; t++) wt[c][t] = (t == c) ? 1 : 0;
            bs[c] = 0;
        end
        sh = 0; rl = 1'b0;
        apply_cfg();
        build_exp(0, 1, WO0);
        send_frame(0, 0, W*H);
        drain();
        checks++; if (got0_q.size() !== exp_q.size()) begin errors++; $display("FAIL chan_count got %0d want %0d", got0_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp_q[i]) begin errors++; $display("FAIL chan_value out=%0d ch=%0d got %0d want %0d", i / OC, i % OC, got0_q[i], exp_q[i]); end
        end
        $display("test_channels outputs=%0d", got0_q.size() / OC);
    endtask

    task automatic test_stride();
        int cw [2] = '{1, -2};
        int ce [2] = '{7, -8};
        fill_img(0, 0, 3);
        for (int k = 0; k < 2; k++) begin
            clear_q();
            set_cfg_const(cw[k], 0, 0, 1'b0);
            send_frame(1, 0, W*H);
            drain();
            checks++; if (gotl1_q.size() !== 4) begin errors++; $display("FAIL stride_count case=%0d got %0d want 4", k, gotl1_q.size()); end
            for (int i = 0; i < got1_q.size(); i++) begin
                checks++; if (got1_q[i] !== ce[k]) begin errors++; $display("FAIL stride_sat case=%0d idx=%0d got %0d want %0d", k, i, got1_q[i], ce[k]); end
            end
            for (int i = 0; i < gotl1_q.size(); i++) begin
                checks++; if (gotl1_q[i] !== (i == 3)) begin errors++; $display("FAIL stride_last idx=%0d got %b want %b", i, gotl1_q[i], i == 3); end
            end
        end
        clear_q();
        fill_img(0, 2, 0);
        set_cfg_rand(2);
        build_exp(0, S1, WO1);
        send_frame(1, 0, W*H);
        drain();
        checks++; if (got1_q.size() !== exp_q.size()) begin errors++; $display("FAIL stride_rcount got %0d want %0d", got1_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got1_q.size(); i++) begin
            checks++; if (got1_q[i] !== exp_q[i]) begin errors++; $display("FAIL stride_rvalue out=%0d ch=%0d got %0d want %0d", i / OC, i % OC, got1_q[i], exp_q[i]); end
        end
        $display("test_stride outputs=%0d", got1_q.size() / OC);
    endtask

    task automatic test_backpressure();
        clear_q();
        fill_img(0, 2, 0);
        set_cfg_rand(2);
        build_exp(0, 1, WO0);
        fork
            send_frame(0, 0, W*H);
            begin
                logic [OC*WO0-1:0] held;
                int n;
                repeat (15) @(posedge clk);
                #1;
                for (n = 0; n < 40 && !vo0; n++) begin
                    @(posedge clk); #1;
                end
                if (!vo0) begin
                    checks++; errors++; $display("FAIL bp_start valid_o never rose");
                end else begin
                    rdy_i0 = 1'b0;
                    held = dout0;
                    repeat (5) begin
                        @(negedge clk);
                        checks++; if (rdy_o0 !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", rdy_o0); end
                        checks++; if (vo0 !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", vo0); end
                        checks++; if (dout0 !== held) begin errors++; $display("FAIL bp_hold got %h want %h", dout0, held); end
                        @(posedge clk); #1;
                    end
                    rdy_i0 = 1'b1;
                end
            end
        join
        drain();
        checks++; if (got0_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got0_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_value out=%0d ch=%0d got %0d want %0d", i / OC, i % OC, got0_q[i], exp_q[i]); end
        end
        $display("test_backpressure outputs=%0d", got0_q.size() / OC);
    endtask

    task automatic test_back_to_back();
        clear_q();
        fill_img(0, 2, 0);
        fill_img(1, 2, 0);
        set_cfg_rand(3);
        build_exp(0, 1, WO0);
        build_exp(1, 1, WO0);
        b2b_done = 1'b0;
        fork
            begin
                send_frame(0, 0, W*H);
                send_frame(0, 1, W*H);
                b2b_done = 1'b1;
            end
            begin
                while (!b2b_done) begin
                    rdy_i0 = ($urandom_range(3) != 0);
                    @(posedge clk); #1;
                end
                rdy_i0 = 1'b1;
            end
        join
        drain();
        checks++; if (got0_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", got0_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_value out=%0d ch=%0d got %0d want %0d", i / OC, i % OC, got0_q[i], exp_q[i]); end
        end
        for (int i = 0; i < expl_q.size() && i < gotl0_q.size(); i++) begin
            checks++; if (gotl0_q[i] !== expl_q[i]) begin errors++; $display("FAIL b2b_last idx=%0d got %b want %b", i, gotl0_q[i], expl_q[i]); end
        end
        $display("test_back_to_back outputs=%0d", gotl0_q.size());
    endtask

    task automatic test_reset_midframe();
        clear_q();
        fill_img(0, 2, 0);
        fill_img(1, 2, 0);
        set_cfg_rand(2);
        send_frame(0, 0, 17);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", vo0); end
        @(posedge clk); #1;
        clear_q();
        build_exp(1, 1, WO0);
        send_frame(0, 1, W*H);
        drain();
        checks++; if (gotl0_q.size() !== 12) begin errors++; $display("FAIL rstmid_count got %0d want 12", gotl0_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
            checks++; if (got0_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_value out=%0d ch=%0d got %0d want %0d", i / OC, i % OC, got0_q[i], exp_q[i]); end
        end
        for (int i = 0; i < expl_q.size() && i < gotl0_q.size(); i++) begin
            checks++; if (gotl0_q[i] !== expl_q[i]) begin errors++; $display("FAIL rstmid_last idx=%0d got %b want %b", i, gotl0_q[i], expl_q[i]); end
        end
        $display("test_reset_midframe outputs=%0d", gotl0_q.size());
    endtask

    initial begin
        test_reset();
        test_constant();
        test_bias_relu_sat();
        test_channels();
        test_stride();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
